// File: rtl/bin2therm_dwa_pipeline_pkg.sv
// Shared constants and helpers for the thermometer DAC front end and its matching decoder.
package bin2therm_dwa_pipeline_pkg;

    localparam int PIPE_DEPTH  = 3;
    localparam int DWA_PTR_RST = 0;

    function automatic int elems(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bin2therm_dwa_pipeline_therm_rotate.sv
// Combinational left rotator over an ELEMS-bit element ring; the rotation is taken modulo ELEMS, not 2**n.
module therm_rotate
    import bin2therm_dwa_pipeline_pkg::*;
#(
    parameter int ELEMS = 255,
    parameter int PTR_W = 8
) (
    input  logic [ELEMS-1:0] word,
    input  logic [PTR_W-1:0] amount,
    output logic [ELEMS-1:0] rotated
);

    logic [ELEMS-1:0] cur;
    logic [ELEMS-1:0] shifted;
    int               sh;

    // Stage i rotates by 2**i reduced mod ELEMS, so the stages compose to amount mod ELEMS.
    always_comb begin
        cur     = word;
        shifted = '0;
        sh      = 0;
        for (int i = 0; i < PTR_W; i++) begin
            sh      = (1 << i) % ELEMS;
            shifted = (cur << sh) | (cur >> (ELEMS - sh));
            if (amount[i]) cur = shifted;
        end
        rotated = cur;
    end

endmodule

// File: rtl/bin2therm_dwa_pipeline.sv
// Binary-to-thermometer converter with optional data-weighted-averaging rotation, three register stages.
module bin2therm_dwa_pipeline
    import bin2therm_dwa_pipeline_pkg::*;
#(
    parameter  int b     = 8,
    parameter  int PTR_W = b,
    localparam int ELEMS = elems(b)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [b-1:0]     bin,
    input  logic             dwa_en,
    output logic [ELEMS-1:0] thermo,
    output logic             valid_out,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W:0] ELEMS_EXT = (PTR_W+1)'(ELEMS);

    logic             valid_p1;
    logic [b-1:0]     bin_p1;
    logic             dwa_en_p1;

    logic             valid_p2;
    logic [b-1:0]     bin_p2;
    logic [ELEMS-1:0] t_p2;
    logic [PTR_W-1:0] r_p2;
    logic [ELEMS-1:0] rot_p2;

    logic [ELEMS-1:0] t_next;
    logic [PTR_W:0]   ptr_sum;
    logic [PTR_W-1:0] ptr_next;

    // ---- S1: input capture ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_p1  <= 1'b0;
            bin_p1    <= '0;
            dwa_en_p1 <= 1'b0;
        end else begin
            valid_p1  <= valid;
            bin_p1    <= bin;
            dwa_en_p1 <= dwa_en;
        end
    end

    // Bits at or above bin stay set after the shift; inverting leaves ones below bin.
    assign t_next = valid_p1 ? ~({ELEMS{1'b1}} << bin_p1) : '0;

    // ptr + bin < 2*ELEMS, so one conditional subtract completes the modulo.
    assign ptr_sum  = {1'b0, ptr} + (PTR_W+1)'(bin_p1);
    assign ptr_next = (ptr_sum >= ELEMS_EXT) ? PTR_W'(ptr_sum - ELEMS_EXT) : ptr_sum[PTR_W-1:0];

    // ---- S2: expand, latch rotation amount, advance pointer ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_p2 <= 1'b0;
            bin_p2   <= '0;
            t_p2     <= '0;
            r_p2     <= '0;
            ptr      <= PTR_W'(DWA_PTR_RST);
        end else begin
            valid_p2 <= valid_p1;
            bin_p2   <= valid_p1 ? bin_p1 : '0;
            t_p2     <= t_next;
            r_p2     <= dwa_en_p1 ? ptr : '0;
            if (valid_p1) ptr <= dwa_en_p1 ? ptr_next : PTR_W'(DWA_PTR_RST);
        end
    end

    therm_rotate #(
        .ELEMS (ELEMS),
        .PTR_W (PTR_W)
    ) u_rotate (
        .word    (t_p2),
        .amount  (r_p2),
        .rotated (rot_p2)
    );

    // ---- S3: rotated output ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thermo    <= '0;
            valid_out <= 1'b0;
        end else begin
            thermo    <= rot_p2;
            valid_out <= valid_p2;
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            assert (PTR_W >= clog2(ELEMS));
            assert ({1'b0, ptr} < ELEMS_EXT);
            if (valid_p2) assert ($countones(rot_p2) == int'(bin_p2));
            if (!valid_out) assert (thermo == '0);
        end
    end

endmodule

// File: tb/tb_bin2therm_dwa_pipeline.sv
// Directed and randomized checks of bin2therm_dwa_pipeline at b=3 and b=8 against a run-placement model.
module tb_bin2therm_dwa_pipeline;
    import bin2therm_dwa_pipeline_pkg::*;

    localparam int E3 = 7;
    localparam int E8 = 255;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic         valid3, dwa3, vo3;
    logic [2:0]   bin3, ptr3;
    logic [6:0]   th3;
    logic         valid8, dwa8, vo8;
    logic [7:0]   bin8, ptr8;
    logic [254:0] th8;

    bin2therm_dwa_pipeline #(.b(3), .PTR_W(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .valid(valid3), .bin(bin3), .dwa_en(dwa3),
        .thermo(th3), .valid_out(vo3), .ptr(ptr3)
    );

    bin2therm_dwa_pipeline #(.b(8), .PTR_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .valid(valid8), .bin(bin8), .dwa_en(dwa8),
        .thermo(th8), .valid_out(vo8), .ptr(ptr8)
    );

    int n_vec = 0;
    int n_err = 0;
    int sn    = 0;
    int mptr [2];
    logic [255:0] hth  [2][4];
    logic         hv   [2][4];
    logic         hde  [2][4];
    int           hptr [2][4];
    int           hbin [2][4];

    function automatic int elem_n(input int d);
        return (d == 0) ? E3 : E8;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each sample occupies bin consecutive ring elements starting at the pointer.
    task automatic model_push(input int d, input logic v, input int bn, input logic de);
        logic [255:0] w;
        int r, e, slot;
        e    = elem_n(d);
        slot = sn % 4;
        w    = '0;
        r    = de ? mptr[d] : 0;
        if (v) for (int j = 0; j < bn; j++) w[(r + j) % e] = 1'b1;
        if (v) mptr[d] = de ? (mptr[d] + bn) % e : 0;
        hth[d][slot]  = w;
        hv[d][slot]   = v;
        hde[d][slot]  = de;
        hbin[d][slot] = v ? bn : 0;
        hptr[d][slot] = mptr[d];
    endtask

    task automatic check_dut(input int d, input logic [255:0] th, input logic vo, input int p);
        logic [255:0] eth;
        logic ev;
        int ep, slot, lead;
        bit run;
        string nm;
        nm   = (d == 0) ? "b3" : "b8";
        eth  = '0;
        ev   = 1'b0;
        ep   = 0;
        slot = 0;
        if (sn >= PIPE_DEPTH - 1) begin
            slot = (sn - PIPE_DEPTH + 1) % 4;
            eth  = hth[d][slot];
            ev   = hv[d][slot];
        end
        if (sn >= 1) ep = hptr[d][(sn - 1) % 4];
        chk({nm, "_thermo"}, th, eth);
        chk({nm, "_valid_out"}, 256'(vo), 256'(ev));
        chk({nm, "_ptr"}, 256'(p), 256'(ep));
        if (ev && !hde[d][slot]) begin
            lead = 0;
            run  = 1'b1;
            for (int k = 0; k < elem_n(d); k++) begin
                if (run && th[k]) lead++;
                else run = 1'b0;
            end
            chk({nm, "_decode"}, 256'(lead), 256'(hbin[d][slot]));
        end
    endtask

    task automatic step(input logic v_3, input int b_3, input logic d_3,
                        input logic v_8, input int b_8, input logic d_8);
        valid3 = v_3; bin3 = 3'(b_3); dwa3 = d_3;
        valid8 = v_8; bin8 = 8'(b_8); dwa8 = d_8;
        model_push(0, v_3, b_3, d_3);
        model_push(1, v_8, b_8, d_8);
        @(posedge clock);
        #1;
        check_dut(0, 256'(th3), vo3, int'(ptr3));
        check_dut(1, 256'(th8), vo8, int'(ptr8));
        sn++;
    endtask

    task automatic s3(input logic v, input int bn, input logic de);
        step(v, bn, de, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_thermo3", 256'(th3), '0);
        chk("rst_valid3", 256'(vo3), '0);
        chk("rst_ptr3", 256'(ptr3), '0);
        chk("rst_thermo8", 256'(th8), '0);
        chk("rst_valid8", 256'(vo8), '0);
        chk("rst_ptr8", 256'(ptr8), '0);
        valid3 = 1'b0; bin3 = '0; dwa3 = 1'b0;
        valid8 = 1'b0; bin8 = '0; dwa8 = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sn      = 0;
        mptr[0] = 0;
        mptr[1] = 0;
    endtask

    function automatic int pick(input int e);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return e;
        return int'($urandom_range(0, e));
    endfunction

    initial begin
        logic de3, de8, v3r, v8r;
        reset_n = 1'b1;
        valid3 = 1'b0; bin3 = '0; dwa3 = 1'b0;
        valid8 = 1'b0; bin8 = '0; dwa8 = 1'b0;
        mptr[0] = 0;
        mptr[1] = 0;
        do_reset();

        // plain thermometer
        s3(1, 5, 0); s3(0, 0, 0); s3(0, 0, 0);
        chk("t2_thermo", 256'(th3), 256'(7'b0011111));
        chk("t2_valid", 256'(vo3), 256'(1'b1));
        chk("t2_ptr", 256'(ptr3), '0);

        // contiguous back-to-back runs
        do_reset();
        s3(1, 3, 1); s3(1, 4, 1); s3(0, 0, 1);
        chk("t3_first", 256'(th3), 256'(7'b0000111));
        s3(0, 0, 1);
        chk("t3_second", 256'(th3), 256'(7'b1111000));
        chk("t3_ptr", 256'(ptr3), '0);

        // wrap across the last element, full word, empty word
        do_reset();
        s3(1, 5, 1); s3(1, 4, 1); s3(1, 7, 1); s3(1, 0, 1);
        chk("t4_wrap", 256'(th3), 256'(7'b1100011));
        s3(0, 0, 1);
        chk("t4_full", 256'(th3), 256'(7'b1111111));
        chk("t4_full_ptr", 256'(ptr3), 256'(2));
        s3(0, 0, 1);
        chk("t4_zero", 256'(th3), '0);
        chk("t4_zero_valid", 256'(vo3), 256'(1'b1));
        chk("t4_zero_ptr", 256'(ptr3), 256'(2));

        // bubble in the middle of a stream
        do_reset();
        s3(1, 2, 1); s3(0, 5, 1); s3(1, 1, 1);
        chk("t5_first", 256'(th3), 256'(7'b0000011));
        s3(0, 0, 1);
        chk("t5_bubble", 256'(th3), '0);
        chk("t5_bubble_valid", 256'(vo3), '0);
        s3(0, 0, 1);
        chk("t5_third", 256'(th3), 256'(7'b0000100));
        chk("t5_ptr", 256'(ptr3), 256'(3));

        // reset with samples in flight, then first-sample latency
        s3(1, 3, 1); s3(1, 2, 1); s3(1, 5, 1);
        do_reset();
        s3(0, 0, 0); s3(0, 0, 0); s3(0, 0, 0);
        s3(1, 6, 0);
        chk("t1_lat1", 256'(vo3), '0);
        s3(0, 0, 0);
        chk("t1_lat2", 256'(vo3), '0);
        s3(0, 0, 0);
        chk("t1_lat3_valid", 256'(vo3), 256'(1'b1));
        chk("t1_lat3_thermo", 256'(th3), 256'(7'b0111111));

        // random soak on both widths with dwa_en toggling
        de3 = 1'b1;
        de8 = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            v3r = ($urandom_range(0, 7) != 0);
            v8r = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) de3 = ~de3;
            if ($urandom_range(0, 7) == 0) de8 = ~de8;
            step(v3r, pick(E3), de3, v8r, pick(E8), de8);
        end
        for (int i = 0; i < PIPE_DEPTH; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
